// File: rtl/tinyalu_pkg.sv
// Shared types and limits for the tinyalu multicycle datapath.
package tinyalu_pkg;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_ADD  = 3'b001,
    OP_AND  = 3'b010,
    OP_XOR  = 3'b011,
    OP_MUL  = 3'b100,
    OP_SUB  = 3'b101,
    OP_ILL6 = 3'b110,
    OP_ILL7 = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/tinyalu_seq_mult.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle while busy.
// product is the accumulator including the current step, so it is the final value when last=1.
module tinyalu_seq_mult
  import tinyalu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               busy,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] product
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  logic [RW-1:0]    acc;
  logic [RW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;

  assign product = mplier[0] ? acc + mcand : acc;
  assign last    = busy && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= RW'(a);
      mplier <= b;
      cnt    <= '0;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tinyalu_multicycle.sv
// tinyalu with single-cycle ADD/AND/XOR/SUB and a WIDTH-cycle multiply behind a start/done handshake.
// start is ignored while busy; illegal opcodes complete immediately with err and a zero result.
module tinyalu_multicycle
  import tinyalu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2*WIDTH-1:0] result
);

  localparam int RW = 2 * WIDTH;

  state_e         state_q, state_d;
  logic           accept;
  logic           mul_load;
  logic           mul_last;
  logic [RW-1:0]  mul_product;
  logic [RW-1:0]  alu_res;
  logic           alu_vld;
  logic           alu_err;

  tinyalu_seq_mult #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (mul_load),
    .busy    (busy),
    .a       (A),
    .b       (B),
    .last    (mul_last),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    mul_load = 1'b0;
    accept   = start && (state_q == ST_IDLE);
    busy     = (state_q == ST_MUL);
    case (state_q)
      ST_IDLE: begin
        if (accept && (op_e'(op) == OP_MUL)) begin
          mul_load = 1'b1;
          state_d  = ST_MUL;
        end
      end
      ST_MUL: begin
        if (mul_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // SUB relies on modulo-2^RW wraparound to produce the sign-extended borrow
  always_comb begin
    alu_res = '0;
    alu_vld = 1'b0;
    alu_err = 1'b0;
    case (op_e'(op))
      OP_ADD: begin alu_res = RW'(A) + RW'(B); alu_vld = 1'b1; end
      OP_AND: begin alu_res = RW'(A & B);      alu_vld = 1'b1; end
      OP_XOR: begin alu_res = RW'(A ^ B);      alu_vld = 1'b1; end
      OP_SUB: begin alu_res = RW'(A) - RW'(B); alu_vld = 1'b1; end
      OP_ILL6, OP_ILL7: begin
        alu_vld = 1'b1;
        alu_err = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      result <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (mul_last) begin
        result <= mul_product;
        done   <= 1'b1;
      end else if (accept && alu_vld) begin
        result <= alu_res;
        done   <= 1'b1;
        err    <= alu_err;
      end
    end
  end

endmodule

// File: tb/tb_tinyalu_multicycle.sv
// Directed bench for tinyalu_multicycle: vector table for single-cycle ops plus multiply/reset sequences.
module tb_tinyalu_multicycle;
  import tinyalu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start8, busy8, done8, err8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic [15:0] result8;

  logic        start16, busy16, done16, err16;
  logic [2:0]  op16;
  logic [15:0] a16, b16;
  logic [31:0] result16;

  tinyalu_multicycle #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .op(op8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .err(err8), .result(result8)
  );

  tinyalu_multicycle #(.WIDTH(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .op(op16), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .err(err16), .result(result16)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        err;
  } vec_t;

  vec_t vecs[10];
  int   n;
  int   pulses;

  initial begin
    vecs[0] = '{3'b001, 8'hFF, 8'h01, 16'h0100, 1'b0};
    vecs[1] = '{3'b101, 8'h05, 8'h07, 16'hFFFE, 1'b0};
    vecs[2] = '{3'b010, 8'hAA, 8'h0F, 16'h000A, 1'b0};
    vecs[3] = '{3'b011, 8'hF0, 8'h3C, 16'h00CC, 1'b0};
    vecs[4] = '{3'b110, 8'h12, 8'h34, 16'h0000, 1'b1};
    vecs[5] = '{3'b001, 8'h80, 8'h80, 16'h0100, 1'b0};
    vecs[6] = '{3'b111, 8'hFF, 8'hFF, 16'h0000, 1'b1};
    vecs[7] = '{3'b101, 8'h00, 8'h01, 16'hFFFF, 1'b0};
    vecs[8] = '{3'b101, 8'h07, 8'h05, 16'h0002, 1'b0};
    vecs[9] = '{3'b011, 8'hFF, 8'h0F, 16'h00F0, 1'b0};

    reset_n = 1'b0;
    start8 = 1'b0; op8 = 3'b000; a8 = '0; b8 = '0;
    start16 = 1'b0; op16 = 3'b000; a16 = '0; b16 = '0;
    @(negedge clk);
    step();
    step();
    chk("rst_result8", 32'(result8), 32'h0);
    chk("rst_done8",   32'(done8),   32'h0);
    chk("rst_err8",    32'(err8),    32'h0);
    chk("rst_busy8",   32'(busy8),   32'h0);
    chk("rst_result16", result16,    32'h0);
    chk("rst_busy16",  32'(busy16),  32'h0);
    reset_n = 1'b1;
    step();

    // Single-cycle vectors, one idle cycle between each
    for (int i = 0; i < 10; i++) begin
      start8 = 1'b1; op8 = vecs[i].op; a8 = vecs[i].a; b8 = vecs[i].b;
      step();
      start8 = 1'b0;
      chk($sformatf("vec%0d_done", i),   32'(done8),   32'h1);
      chk($sformatf("vec%0d_err", i),    32'(err8),    32'(vecs[i].err));
      chk($sformatf("vec%0d_result", i), 32'(result8), 32'(vecs[i].res));
      chk($sformatf("vec%0d_busy", i),   32'(busy8),   32'h0);
      step();
      chk($sformatf("vec%0d_done_drop", i), 32'(done8), 32'h0);
    end

    // SUB then NOP: NOP leaves result untouched and produces no done
    start8 = 1'b1; op8 = 3'b101; a8 = 8'h05; b8 = 8'h07;
    step();
    op8 = 3'b000; a8 = 8'h11; b8 = 8'h22;
    step();
    start8 = 1'b0;
    chk("nop_done",   32'(done8),   32'h0);
    chk("nop_result", 32'(result8), 32'hFFFE);

    // MUL 0xFF*0xFF with ignored starts at N+3 and at the busy-falling edge N+8
    start8 = 1'b1; op8 = 3'b100; a8 = 8'hFF; b8 = 8'hFF;
    step();
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    chk("mul_busy_k0", 32'(busy8), 32'h1);
    chk("mul_done_k0", 32'(done8), 32'h0);
    for (int k = 1; k < 8; k++) begin
      if (k == 3) begin start8 = 1'b1; op8 = 3'b001; a8 = 8'h01; b8 = 8'h01; end
      step();
      start8 = 1'b0;
      chk($sformatf("mul_busy_k%0d", k), 32'(busy8), 32'h1);
      chk($sformatf("mul_done_k%0d", k), 32'(done8), 32'h0);
    end
    start8 = 1'b1; op8 = 3'b001; a8 = 8'h01; b8 = 8'h01;
    step();
    start8 = 1'b0;
    chk("mul_done",   32'(done8),   32'h1);
    chk("mul_busy",   32'(busy8),   32'h0);
    chk("mul_err",    32'(err8),    32'h0);
    chk("mul_result", 32'(result8), 32'hFE01);
    step();
    chk("mul_after_done",   32'(done8),   32'h0);
    chk("mul_after_result", 32'(result8), 32'hFE01);

    // Reset mid-multiply discards the partial product
    start8 = 1'b1; op8 = 3'b100; a8 = 8'h12; b8 = 8'h34;
    step();
    start8 = 1'b0;
    step(); step(); step();
    chk("midrst_busy_pre", 32'(busy8), 32'h1);
    reset_n = 1'b0;
    step();
    chk("midrst_result", 32'(result8), 32'h0);
    chk("midrst_busy",   32'(busy8),   32'h0);
    chk("midrst_done",   32'(done8),   32'h0);
    reset_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done8 === 1'b1 || busy8 === 1'b1) pulses++;
    end
    chk("midrst_no_activity", 32'(pulses), 32'h0);
    start8 = 1'b1; op8 = 3'b011; a8 = 8'hF0; b8 = 8'h3C;
    step();
    start8 = 1'b0;
    chk("postrst_xor_done",   32'(done8),   32'h1);
    chk("postrst_xor_result", 32'(result8), 32'h00CC);
    step();

    // Illegal op followed by back-to-back ANDs: done stays high
    start8 = 1'b1; op8 = 3'b110; a8 = 8'h55; b8 = 8'h66;
    step();
    chk("ill_done",   32'(done8),   32'h1);
    chk("ill_err",    32'(err8),    32'h1);
    chk("ill_result", 32'(result8), 32'h0);
    op8 = 3'b010; a8 = 8'hAA; b8 = 8'h0F;
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("b2b_and%0d_done", k),   32'(done8),   32'h1);
      chk($sformatf("b2b_and%0d_err", k),    32'(err8),    32'h0);
      chk($sformatf("b2b_and%0d_result", k), 32'(result8), 32'h000A);
    end
    start8 = 1'b0;
    step();
    chk("b2b_done_drop", 32'(done8), 32'h0);

    // WIDTH=16 multiply latency and result
    start16 = 1'b1; op16 = 3'b100; a16 = 16'hFFFF; b16 = 16'h0002;
    step();
    start16 = 1'b0; a16 = 16'h0; b16 = 16'h0;
    n = 0;
    while (done16 !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("mul16_done",    32'(done16), 32'h1);
    chk("mul16_latency", 32'(n),      32'd16);
    chk("mul16_result",  result16,    32'h0001FFFE);
    chk("mul16_busy",    32'(busy16), 32'h0);
    chk("mul16_err",     32'(err16),  32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
